// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit, 8-register CPU core control path:
// opcode field constants, instruction classes, sequencer states and
// write-back source encodings.
package cpu_isa_pkg;

  // ir[15:14] == 2'b11 marks a load-immediate regardless of the lower bits.
  localparam logic [1:0] LDI_PREFIX = 2'b11;

  // Full 5-bit opcodes in ir[15:11] for the 10xxx group.
  localparam logic [4:0] OP_LD   = 5'b10100;
  localparam logic [4:0] OP_ST   = 5'b10101;
  localparam logic [4:0] OP_HALT = 5'b10110;
  localparam logic [4:0] OP_BRN  = 5'b10111;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_HALT = 3'd4,
    CLS_BRN  = 3'd5,
    CLS_NOP  = 3'd6
  } instr_class_e;

  // Encoding is visible on the debug 'state' port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Write-back source select driven to the register-file input mux.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: maps the opcode field ir[15:11]
// to an instruction class and the register write-back source for it.
module instr_decode
  import cpu_isa_pkg::*;
(
  input  logic [4:0]   op_i,
  output instr_class_e cls_o,
  output logic [1:0]   wb_sel_o
);

  // Classify the opcode, then pick the write-back source for that class.
  always_comb begin
    cls_o    = CLS_NOP;
    wb_sel_o = WB_ALU;

    if (op_i[4:3] == LDI_PREFIX) begin
      cls_o = CLS_LDI;
    end else if (op_i[4] == 1'b0) begin
      // 00xxx / 01xxx: the ALU decodes its own function fields.
      cls_o = CLS_ALU;
    end else begin
      case (op_i)
        OP_LD:   cls_o = CLS_LD;
        OP_ST:   cls_o = CLS_ST;
        OP_HALT: cls_o = CLS_HALT;
        OP_BRN:  cls_o = CLS_BRN;
        default: cls_o = CLS_NOP;
      endcase
    end

    case (cls_o)
      CLS_LDI: wb_sel_o = WB_IMM;
      CLS_LD:  wb_sel_o = WB_MEM;
      default: wb_sel_o = WB_ALU;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: owns PC and IR, fetches from the combinational
// ROM and walks each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing
// one-cycle strobes to the datapath. Branches and HALT are resolved here.
//
// Memory handshake: mem_req is a request held high (with mem_we/mem_addr
// stable) for every MEM cycle until the cycle in which mem_ack is sampled
// high; that cycle completes the transfer. mem_ack outside MEM is ignored.
module instr_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_data,
  output logic [15:0]     ir,
  output logic            alu_en,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  input  logic            reg_neg,
  output logic            mem_req,
  output logic            mem_we,
  output logic [7:0]      mem_addr,
  input  logic            mem_ack,
  output logic            halted,
  output logic [2:0]      state
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            neg_q, neg_d;

  instr_class_e    cls;
  logic [1:0]      dec_wb_sel;
  logic [PC_W-1:0] br_off;

  instr_decode u_decode (
    .op_i     (ir_q[15:11]),
    .cls_o    (cls),
    .wb_sel_o (dec_wb_sel)
  );

  // Signed 8-bit branch offset widened to the PC width.
  assign br_off = PC_W'($signed(ir_q[7:0]));

  assign rom_addr = pc_q;
  assign ir       = ir_q;
  assign mem_addr = ir_q[7:0];
  assign state    = state_q;

  // State, PC, IR and the sign flag captured in DECODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state logic and one-cycle control strobes, all decoded from state_q.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    neg_d   = neg_q;
    alu_en  = 1'b0;
    rf_we   = 1'b0;
    wb_sel  = WB_ALU;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // The register file presents ir[10:8] this cycle; keep its sign.
        neg_d   = reg_neg;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_en  = 1'b1;
            state_d = ST_WB;
          end
          CLS_LDI:         state_d = ST_WB;
          CLS_LD, CLS_ST:  state_d = ST_MEM;
          CLS_HALT:        state_d = ST_HALT;
          CLS_BRN: begin
            // PC already points past the branch; step back to its address.
            if (neg_q) pc_d = pc_q - PC_W'(1) + br_off;
            state_d = ST_FETCH;
          end
          default:         state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CLS_ST);
        if (mem_ack) state_d = (cls == CLS_ST) ? ST_FETCH : ST_WB;
      end

      ST_WB: begin
        rf_we   = 1'b1;
        wb_sel  = dec_wb_sel;
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program fragments plus randomized
// programs, checked instruction-by-instruction against a behavioural model
// that predicts latency, strobes and the next PC from the ISA rules.
module tb_instr_sequencer;
  import cpu_isa_pkg::*;

  localparam int K_ALU = 0, K_LDI = 1, K_LD = 2, K_ST = 3,
                 K_HALT = 4, K_BRN = 5, K_NOP = 6;

  logic        clk = 1'b0;
  logic        reset_n, run, reg_neg, mem_ack;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data, ir;
  logic        alu_en, rf_we, mem_req, mem_we, halted;
  logic [1:0]  wb_sel;
  logic [7:0]  mem_addr;
  logic [2:0]  state;

  logic [15:0] rom [256];
  int          total, bad;
  int          pc_m;
  logic [15:0] last_ir;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ir       (ir),
    .alu_en   (alu_en),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .reg_neg  (reg_neg),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .halted   (halted),
    .state    (state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [15:0] w);
    if (w[15:14] == 2'b11) return K_LDI;
    if (w[15] == 1'b0)     return K_ALU;
    case (w[15:11])
      5'h14:   return K_LD;
      5'h15:   return K_ST;
      5'h16:   return K_HALT;
      5'h17:   return K_BRN;
      default: return K_NOP;
    endcase
  endfunction

  // full=0: only ALU/LDI/NOP (straight-line code); full=1 adds LD/ST/BRN.
  function automatic logic [15:0] rand_word(input bit full);
    int          k;
    logic [15:0] r;
    logic [4:0]  nop_op;
    k = full ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2));
    r = 16'($urandom);
    nop_op = 5'b10000 + 5'($urandom_range(0, 3));
    case (k)
      0:       return {1'b0, r[14:0]};
      1:       return {2'b11, r[13:0]};
      2:       return {nop_op, r[10:0]};
      3:       return {5'b10100, r[10:0]};
      4:       return {5'b10101, r[10:0]};
      default: return {5'b10111, r[10:0]};
    endcase
  endfunction

  // Executes the instruction at the model PC, starting at a negedge in FETCH
  // with run=1, and compares the observed cycle-by-cycle behaviour against
  // what the ISA rules predict for that word.
  task automatic exec_one(input int wait_n, input bit neg);
    logic [15:0] w;
    logic [1:0]  exp_wb, wb_at;
    int          kind, exp_lat, exp_mem, exp_pc, off;
    int          cyc, rf_cnt, rf_at, alu_cnt, memc;
    bit          exp_rf, done;

    w       = rom[pc_m[7:0]];
    reg_neg = neg;
    kind    = classify(w);
    off     = int'($signed(w[7:0]));
    exp_pc  = (pc_m + 1) % 256;
    exp_rf  = 1'b0;
    exp_wb  = 2'b00;
    exp_mem = 0;
    case (kind)
      K_ALU:  begin exp_lat = 4; exp_rf = 1'b1; exp_wb = 2'b00; end
      K_LDI:  begin exp_lat = 4; exp_rf = 1'b1; exp_wb = 2'b01; end
      K_LD:   begin exp_lat = 5 + wait_n; exp_rf = 1'b1; exp_wb = 2'b10; exp_mem = wait_n + 1; end
      K_ST:   begin exp_lat = 4 + wait_n; exp_mem = wait_n + 1; end
      K_HALT: exp_lat = 3;
      K_BRN:  begin
        exp_lat = 3;
        if (neg) exp_pc = ((pc_m + off) % 256 + 256) % 256;
      end
      default: exp_lat = 3;
    endcase

    cyc = 0; rf_cnt = 0; rf_at = 0; alu_cnt = 0; memc = 0; wb_at = 2'b00; done = 1'b0;
    while (!done && cyc < 64) begin
      cyc++;
      if (rf_we) begin rf_cnt++; rf_at = cyc; wb_at = wb_sel; end
      if (alu_en) alu_cnt++;
      if (mem_req) begin
        memc++;
        check("mem_we", mem_we, (kind == K_ST) ? 1 : 0);
        check("mem_addr", mem_addr, w[7:0]);
        mem_ack = (memc > wait_n);
      end else begin
        check("mem_we_idle", mem_we, 0);
        mem_ack = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);
      if (state == ST_FETCH || state == ST_HALT) done = 1'b1;
    end
    mem_ack = 1'b0;

    check("finished", done, 1);
    check("latency", cyc, exp_lat);
    check("rf_we_cnt", rf_cnt, exp_rf ? 1 : 0);
    if (exp_rf) begin
      check("rf_we_cycle", rf_at, exp_lat);
      check("wb_sel", wb_at, exp_wb);
    end
    check("alu_en_cnt", alu_cnt, (kind == K_ALU) ? 1 : 0);
    check("mem_cycles", memc, exp_mem);
    check("ir", ir, w);
    check("halted", halted, (kind == K_HALT) ? 1 : 0);
    check("next_pc", rom_addr, exp_pc);
    pc_m    = exp_pc;
    last_ir = w;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pc_m    = 0;
    @(negedge clk);
  endtask

  initial begin
    int prev;
    total = 0; bad = 0;
    reset_n = 1'b0; run = 1'b0; reg_neg = 1'b0; mem_ack = 1'b0;
    last_ir = 16'h0000;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

    // Directed program: LDI, straight-line ALU ops, branch not taken,
    // delayed store, immediate load, taken backward branch to 0x00.
    rom[8'h00] = 16'hC000;
    for (int i = 1; i < 12; i++) rom[i] = {2'b00, 14'($urandom)};
    rom[8'h0C] = 16'hB903;
    rom[8'h0D] = 16'hA941;
    rom[8'h0E] = 16'hA441;
    rom[8'h0F] = 16'hB9F1;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_state", state, ST_FETCH);
    check("rst_pc", rom_addr, 8'h00);
    check("rst_ir", ir, 16'h0000);
    check("rst_alu_en", alu_en, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_wb_sel", wb_sel, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_halted", halted, 0);
    reset_n = 1'b1;
    pc_m    = 0;
    @(negedge clk);

    run = 1'b1;
    exec_one(0, 1'b0);
    check("ldi_pc", rom_addr, 8'h01);
    for (int i = 1; i < 12; i++) exec_one(0, 1'($urandom_range(0, 1)));
    exec_one(0, 1'b0);
    check("brn_not_taken", rom_addr, 8'h0D);
    exec_one(3, 1'b0);
    exec_one(0, 1'b0);
    exec_one(0, 1'b1);
    check("brn_taken", rom_addr, 8'h00);

    // run low in FETCH: nothing moves
    run = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_ir", ir, last_ir);
      check("stall_pc", rom_addr, 8'h00);
      check("stall_state", state, ST_FETCH);
      check("stall_rf_we", rf_we, 0);
    end

    // Asynchronous reset in the middle of a store's MEM phase
    rom[8'h00] = 16'hA955;
    run = 1'b1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_mem_we", mem_we, 0);
    check("async_pc", rom_addr, 8'h00);
    check("async_state", state, ST_FETCH);
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_rf_we", rf_we, 0);
      check("rst_hold_mem_req", mem_req, 0);
    end
    reset_n = 1'b1;
    pc_m = 0;
    @(negedge clk);

    // HALT is sticky under run=1
    rom[8'h00] = 16'hB000;
    run = 1'b1;
    exec_one(0, 1'b0);
    repeat (10) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_halted", halted, 1);
      check("halt_pc", rom_addr, 8'h01);
      check("halt_rf_we", rf_we, 0);
      check("halt_mem_req", mem_req, 0);
      check("halt_alu_en", alu_en, 0);
    end

    // Straight-line code through the whole ROM: PC wraps FF -> 00
    for (int i = 0; i < 256; i++) rom[i] = rand_word(1'b0);
    rom[8'hFF] = {2'b01, 14'($urandom)};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 257; i++) begin
      prev = pc_m;
      exec_one(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      if (prev == 255) check("pc_wrap", rom_addr, 8'h00);
    end

    // Random programs with memory waits and branches
    for (int i = 0; i < 256; i++) rom[i] = rand_word(1'b1);
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 200; i++)
      exec_one(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
